dataout_packer: RTL and testbench

//  Parametrised byte packer between readout data FIFO (FWFT) and USB transmit interface.

---
 rtl/dataout_packer.sv | 172 +++++++++++++++++
 tb/tb_dataout_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataout_packer.sv
// dataout_packer: unpacks IN_BYTES-wide FWFT FIFO words one byte per cycle and
// repacks them into OUT_BYTES-wide USB words, with stop and idle-timeout flush.
//
// state              | meaning
// -------------------+--------------------------------------------------------
// ST_RESET    (000)  | first cycle after reset, moves to IDLE
// ST_IDLE     (001)  | waiting for enable; run counters cleared on exit
// ST_PACK     (010)  | moving one byte per cycle from FIFO word into accumulator
// ST_WAIT     (101)  | FIFO empty, byte positions held, idle-timeout running
// ST_TX_CONT  (110)  | presenting a word to the sink, packing resumes after
// ST_TX_END   (111)  | presenting the final word of the run (usb_last=1)
module dataout_packer #(
  parameter int IN_BYTES        = 3,
  parameter int OUT_BYTES       = 4,
  parameter int FLUSH_TIMEOUT   = 256,
  parameter int StateBitWidth_c = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       fsm_stop,
  input  logic [IN_BYTES*8-1:0]      fifoin_data,
  input  logic                       fifoin_empty,
  output logic                       fifoin_rd_en,
  output logic [OUT_BYTES*8-1:0]     usb_data,
  output logic [OUT_BYTES-1:0]       usb_byte_en,
  output logic                       usb_valid,
  output logic                       usb_last,
  input  logic                       usb_ready,
  output logic [StateBitWidth_c-1:0] state,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                byte_count
);

  localparam int InIdxW  = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int OutIdxW = $clog2(OUT_BYTES + 1);
  localparam int TmoW    = $clog2(FLUSH_TIMEOUT + 2);

  typedef enum logic [2:0] {
    ST_RESET   = 3'b000,
    ST_IDLE    = 3'b001,
    ST_PACK    = 3'b010,
    ST_WAIT    = 3'b101,
    ST_TX_CONT = 3'b110,
    ST_TX_END  = 3'b111
  } state_t;

  state_t                 state_q, state_d;
  logic [InIdxW-1:0]      in_idx_q, in_idx_d;
  logic [OutIdxW-1:0]     out_idx_q, out_idx_d;
  logic [OUT_BYTES*8-1:0] acc_q, acc_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [31:0]            bc_q, bc_d;
  logic                   done_q, done_d;
  logic                   rd_en_c;
  logic [7:0]             cur_byte;
  logic [OUT_BYTES-1:0]   lane_en;
  logic                   tx_state;

  assign cur_byte = fifoin_data[8*int'(in_idx_q) +: 8];

  // Valid lanes are contiguous from lane 0; out_idx is the number of filled lanes.
  always_comb begin
    lane_en = '0;
    for (int j = 0; j < OUT_BYTES; j++) lane_en[j] = (j < int'(out_idx_q));
  end

  // Register update; reset discards any partial word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      bc_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      bc_q      <= bc_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath and FIFO pop decisions.
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    acc_d     = acc_q;
    tmo_d     = '0;
    bc_d      = bc_q;
    done_d    = 1'b0;
    rd_en_c   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable && !fsm_stop) begin
          state_d   = ST_PACK;
          bc_d      = '0;
          in_idx_d  = '0;
          out_idx_d = '0;
          acc_d     = '0;
        end
      end
      ST_PACK, ST_WAIT: begin
        // A stop only lets a byte through when that byte completes the word.
        if (state_q == ST_PACK && !fifoin_empty &&
            (!fsm_stop || out_idx_q == OutIdxW'(OUT_BYTES - 1))) begin
          acc_d[8*int'(out_idx_q) +: 8] = cur_byte;
          out_idx_d = out_idx_q + OutIdxW'(1);
          if (in_idx_q == InIdxW'(IN_BYTES - 1)) begin
            rd_en_c  = 1'b1;
            in_idx_d = '0;
          end else begin
            in_idx_d = in_idx_q + InIdxW'(1);
          end
          if (out_idx_q == OutIdxW'(OUT_BYTES - 1))
            state_d = fsm_stop ? ST_TX_END : ST_TX_CONT;
        end else if (fsm_stop) begin
          // Drop the rest of a half-consumed FIFO word so the next run starts aligned.
          if (in_idx_q != '0 && !fifoin_empty) rd_en_c = 1'b1;
          in_idx_d = '0;
          if (out_idx_q != '0) begin
            state_d = ST_TX_END;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (state_q == ST_PACK) begin
          state_d = ST_WAIT;
        end else if (!fifoin_empty) begin
          state_d = ST_PACK;
        end else if (FLUSH_TIMEOUT != 0 && out_idx_q != '0) begin
          if (tmo_q + TmoW'(1) == TmoW'(FLUSH_TIMEOUT)) state_d = ST_TX_CONT;
          else tmo_d = tmo_q + TmoW'(1);
        end
      end
      ST_TX_CONT, ST_TX_END: begin
        if (usb_ready) begin
          bc_d      = bc_q + 32'(out_idx_q);
          acc_d     = '0;
          out_idx_d = '0;
          if (state_q == ST_TX_END || fsm_stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PACK;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign tx_state     = (state_q == ST_TX_CONT) || (state_q == ST_TX_END);
  assign usb_valid    = tx_state;
  assign usb_last     = (state_q == ST_TX_END);
  assign usb_byte_en  = tx_state ? lane_en : '0;
  assign usb_data     = acc_q;
  assign fifoin_rd_en = rd_en_c;
  assign busy         = (state_q != ST_RESET) && (state_q != ST_IDLE);
  assign done         = done_q;
  assign byte_count   = bc_q;
  assign state        = StateBitWidth_c'(state_q);

endmodule

// File: tb/tb_dataout_packer.sv
`timescale 1ns/1ps
// Bench for dataout_packer: directed vector table plus multi-cycle corner sequences.
module tb_dataout_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: IN=3, OUT=4, short flush timeout
  logic        enable, fsm_stop, usb_ready;
  logic [23:0] fifoin_data;
  logic        fifoin_empty, fifoin_rd_en;
  logic [31:0] usb_data;
  logic [3:0]  usb_byte_en;
  logic        usb_valid, usb_last;
  logic [2:0]  state;
  logic        busy, done;
  logic [31:0] byte_count;

  dataout_packer #(.IN_BYTES(3), .OUT_BYTES(4), .FLUSH_TIMEOUT(8), .StateBitWidth_c(3)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fsm_stop(fsm_stop),
    .fifoin_data(fifoin_data), .fifoin_empty(fifoin_empty), .fifoin_rd_en(fifoin_rd_en),
    .usb_data(usb_data), .usb_byte_en(usb_byte_en), .usb_valid(usb_valid),
    .usb_last(usb_last), .usb_ready(usb_ready), .state(state), .busy(busy),
    .done(done), .byte_count(byte_count));

  // Instance B: IN=2, OUT=3, timeout disabled
  logic        b_enable, b_stop, b_ready;
  logic [15:0] b_fdata;
  logic        b_fempty, b_rd_en;
  logic [23:0] b_udata;
  logic [2:0]  b_be;
  logic        b_valid, b_last;
  logic [2:0]  b_state;
  logic        b_busy, b_done;
  logic [31:0] b_bcount;

  dataout_packer #(.IN_BYTES(2), .OUT_BYTES(3), .FLUSH_TIMEOUT(0), .StateBitWidth_c(3)) u_dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .fsm_stop(b_stop),
    .fifoin_data(b_fdata), .fifoin_empty(b_fempty), .fifoin_rd_en(b_rd_en),
    .usb_data(b_udata), .usb_byte_en(b_be), .usb_valid(b_valid),
    .usb_last(b_last), .usb_ready(b_ready), .state(b_state), .busy(b_busy),
    .done(b_done), .byte_count(b_bcount));

  // FWFT FIFO models
  logic [23:0] mem1 [0:15];
  logic [15:0] mem2 [0:15];
  logic [7:0]  wp1, rp1, wp2, rp2;
  logic        clr1;
  assign fifoin_data  = mem1[rp1[3:0]];
  assign fifoin_empty = (rp1 == wp1);
  assign b_fdata      = mem2[rp2[3:0]];
  assign b_fempty     = (rp2 == wp2);

  always @(posedge clk) begin
    if (rst || clr1) rp1 <= wp1;
    else if (fifoin_rd_en) rp1 <= rp1 + 8'd1;
    if (rst) rp2 <= wp2;
    else if (b_rd_en) rp2 <= rp2 + 8'd1;
  end

  // Output monitors
  logic [31:0] lg_data [0:63];
  logic [3:0]  lg_be   [0:63];
  logic        lg_last [0:63];
  logic [23:0] lgb_data [0:15];
  logic [2:0]  lgb_be   [0:15];
  logic        lgb_last [0:15];
  int lg_n = 0, rd_n = 0, done_n = 0, viol_n = 0;
  int lgb_n = 0, rdb_n = 0, doneb_n = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (usb_valid && usb_ready) begin
        lg_data[lg_n % 64] <= usb_data;
        lg_be[lg_n % 64]   <= usb_byte_en;
        lg_last[lg_n % 64] <= usb_last;
        lg_n <= lg_n + 1;
      end
      if (fifoin_rd_en) rd_n <= rd_n + 1;
      if (done) done_n <= done_n + 1;
      if ((fifoin_rd_en && fifoin_empty) || (b_rd_en && b_fempty)) viol_n <= viol_n + 1;
      if (b_valid && b_ready) begin
        lgb_data[lgb_n % 16] <= b_udata;
        lgb_be[lgb_n % 16]   <= b_be;
        lgb_last[lgb_n % 16] <= b_last;
        lgb_n <= lgb_n + 1;
      end
      if (b_rd_en) rdb_n <= rdb_n + 1;
      if (b_done) doneb_n <= doneb_n + 1;
    end
  end

  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [23:0] w);
    mem1[wp1[3:0]] = w;
    wp1 = wp1 + 8'd1;
  endtask

  task automatic push2(input logic [15:0] w);
    mem2[wp2[3:0]] = w;
    wp2 = wp2 + 8'd1;
  endtask

  // Waits for the drained WAIT state, requests stop, waits for the done pulse.
  task automatic stop_and_wait1();
    int cyc;
    cyc = 0;
    while (!(state == 3'b101 && fifoin_empty) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_wait", 32'(cyc < 200), 32'd1);
    fsm_stop = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    chk("done_seen", 32'(cyc < 50), 32'd1);
    fsm_stop = 1'b0;
    enable   = 1'b0;
    @(negedge clk);
  endtask

  typedef struct packed {
    int               n_in;
    logic [3:0][23:0] w;
    int               n_out;
    logic [2:0][31:0] d;
    logic [2:0][3:0]  be;
    logic [2:0]       last;
    logic [31:0]      bc;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input int id, input vec_t v, input int stall);
    int b_lg, b_rd, b_dn, cyc, rb;
    b_lg = lg_n; b_rd = rd_n; b_dn = done_n;
    for (int i = 0; i < v.n_in; i++) push1(v.w[i]);
    usb_ready = (stall == 0);
    enable    = 1'b1;
    if (stall > 0) begin
      cyc = 0;
      while (!usb_valid && cyc < 50) begin @(negedge clk); cyc++; end
      chk($sformatf("v%0d_stall_reach", id), 32'(cyc < 50), 32'd1);
      rb = rd_n;
      for (int k = 0; k < stall; k++) begin
        chk($sformatf("v%0d_stall_valid%0d", id, k), 32'(usb_valid), 32'd1);
        chk($sformatf("v%0d_stall_data%0d", id, k), usb_data, v.d[0]);
        @(negedge clk);
      end
      chk($sformatf("v%0d_stall_no_rd", id), 32'(rd_n), 32'(rb));
      usb_ready = 1'b1;
    end
    stop_and_wait1();
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_words", id), 32'(lg_n - b_lg), 32'(v.n_out));
    for (int i = 0; i < v.n_out; i++) begin
      chk($sformatf("v%0d_data%0d", id, i), lg_data[(b_lg + i) % 64], v.d[i]);
      chk($sformatf("v%0d_be%0d", id, i), 32'(lg_be[(b_lg + i) % 64]), 32'(v.be[i]));
      chk($sformatf("v%0d_last%0d", id, i), 32'(lg_last[(b_lg + i) % 64]), 32'(v.last[i]));
    end
    chk($sformatf("v%0d_rd_pulses", id), 32'(rd_n - b_rd), 32'(v.n_in));
    chk($sformatf("v%0d_byte_count", id), byte_count, v.bc);
    chk($sformatf("v%0d_done_pulses", id), 32'(done_n - b_dn), 32'd1);
    chk($sformatf("v%0d_idle", id), 32'(state), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, cnt, b_lg, b_dn, b_rd;
    total = 0; bad = 0;
    wp1 = 8'd0; wp2 = 8'd0; clr1 = 1'b0;
    rst = 1'b1; enable = 1'b0; fsm_stop = 1'b0; usb_ready = 1'b1;
    b_enable = 1'b0; b_stop = 1'b0; b_ready = 1'b1;

    vecs[0] = '{2, {24'h0, 24'h0, 24'h060504, 24'h030201}, 2,
                {32'h0, 32'h00000605, 32'h04030201}, {4'h0, 4'b0011, 4'b1111}, 3'b010, 32'd6};
    vecs[1] = '{1, {24'h0, 24'h0, 24'h0, 24'haabbcc}, 1,
                {32'h0, 32'h0, 32'h00aabbcc}, {4'h0, 4'h0, 4'b0111}, 3'b001, 32'd3};
    vecs[2] = '{0, '0, 0, '0, '0, 3'b000, 32'd0};
    vecs[3] = '{4, {24'h0c0b0a, 24'h090807, 24'h060504, 24'h030201}, 3,
                {32'h0c0b0a09, 32'h08070605, 32'h04030201}, {4'hf, 4'hf, 4'hf}, 3'b000, 32'd12};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_valid", 32'(usb_valid), 32'h0);
    chk("rst_rd_en", 32'(fifoin_rd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_data", usb_data, 32'h0);
    chk("rst_byte_count", byte_count, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(state), 32'h1);
    chk("post_rst_idle_b", 32'(b_state), 32'h1);

    // Table-driven runs
    for (int i = 0; i < 4; i++) run_vec(i, vecs[i], 0);

    // Sink stall of 10 cycles on a complete word
    run_vec(10, vecs[0], 10);

    // Idle-timeout flush of a 3-byte partial word, then restart at lane 0
    b_lg = lg_n;
    push1(24'h030201);
    usb_ready = 1'b1; enable = 1'b1;
    cyc = 0;
    while (state != 3'b101 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("tmo_reach_wait", 32'(cyc < 50), 32'd1);
    cnt = 0;
    while (state == 3'b101 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("tmo_wait_cycles", 32'(cnt), 32'd8);
    chk("tmo_state", 32'(state), 32'h6);
    chk("tmo_data", usb_data, 32'h00030201);
    chk("tmo_be", 32'(usb_byte_en), 32'h7);
    chk("tmo_last", 32'(usb_last), 32'h0);
    @(negedge clk);
    push1(24'h060504);
    stop_and_wait1();
    repeat (2) @(negedge clk);
    chk("tmo_words", 32'(lg_n - b_lg), 32'd2);
    chk("tmo_w1_data", lg_data[(b_lg + 1) % 64], 32'h00060504);
    chk("tmo_w1_be", 32'(lg_be[(b_lg + 1) % 64]), 32'h7);
    chk("tmo_w1_last", 32'(lg_last[(b_lg + 1) % 64]), 32'h1);
    chk("tmo_byte_count", byte_count, 32'd6);

    // Stop in the same cycle as the 4th byte: single full last word
    b_lg = lg_n; b_dn = done_n;
    push1(24'h332211); push1(24'h665544);
    usb_ready = 1'b1; enable = 1'b1;
    cyc = 0;
    while (state != 3'b010 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("s4_reach_pack", 32'(cyc < 20), 32'd1);
    repeat (3) @(negedge clk);
    fsm_stop = 1'b1;
    @(negedge clk);
    chk("s4_state_txend", 32'(state), 32'h7);
    chk("s4_data", usb_data, 32'h44332211);
    chk("s4_be", 32'(usb_byte_en), 32'hf);
    chk("s4_last", 32'(usb_last), 32'h1);
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("s4_done_seen", 32'(cyc < 20), 32'd1);
    fsm_stop = 1'b0; enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("s4_words", 32'(lg_n - b_lg), 32'd1);
    chk("s4_done_pulses", 32'(done_n - b_dn), 32'd1);
    chk("s4_byte_count", byte_count, 32'd4);
    clr1 = 1'b1; @(negedge clk); clr1 = 1'b0;

    // Reset asserted while a word waits in TX_AND_CONTINUE
    push1(24'h0a0908); push1(24'h0d0c0b);
    usb_ready = 1'b0; enable = 1'b1;
    cyc = 0;
    while (!usb_valid && cyc < 30) begin @(negedge clk); cyc++; end
    chk("rst_mid_reach", 32'(cyc < 30), 32'd1);
    chk("rst_mid_state_txc", 32'(state), 32'h6);
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(usb_valid), 32'h0);
    chk("rst_mid_state", 32'(state), 32'h0);
    chk("rst_mid_data", usb_data, 32'h0);
    chk("rst_mid_be", 32'(usb_byte_en), 32'h0);
    chk("rst_mid_byte_count", byte_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", 32'(state), 32'h1);
    usb_ready = 1'b1;

    // Instance B: 3 two-byte words into two three-byte words
    b_lg = lgb_n; b_rd = rdb_n; b_dn = doneb_n;
    push2(16'h0201); push2(16'h0403); push2(16'h0605);
    b_enable = 1'b1;
    cyc = 0;
    while (!(b_state == 3'b101 && b_fempty) && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b_reach_wait", 32'(cyc < 100), 32'd1);
    b_stop = 1'b1;
    cyc = 0;
    while (!b_done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b_done_seen", 32'(cyc < 20), 32'd1);
    b_stop = 1'b0; b_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_words", 32'(lgb_n - b_lg), 32'd2);
    chk("b_w0_data", 32'(lgb_data[b_lg % 16]), 32'h030201);
    chk("b_w0_be", 32'(lgb_be[b_lg % 16]), 32'h7);
    chk("b_w0_last", 32'(lgb_last[b_lg % 16]), 32'h0);
    chk("b_w1_data", 32'(lgb_data[(b_lg + 1) % 16]), 32'h060504);
    chk("b_w1_be", 32'(lgb_be[(b_lg + 1) % 16]), 32'h7);
    chk("b_w1_last", 32'(lgb_last[(b_lg + 1) % 16]), 32'h0);
    chk("b_rd_pulses", 32'(rdb_n - b_rd), 32'd3);
    chk("b_byte_count", b_bcount, 32'd6);
    chk("b_done_pulses", 32'(doneb_n - b_dn), 32'd1);

    chk("rd_en_while_empty", 32'(viol_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
